// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state definitions shared by seq_alu_core and seq_muldiv
// Purpose: opcode encodings, controller state type and opcode class helper.
// Ports: none (package).
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_SLL  = 4'h5;
   localparam logic [3:0] OP_SRL  = 4'h6;
   localparam logic [3:0] OP_SRA  = 4'h7;
   localparam logic [3:0] OP_SLT  = 4'h8;
   localparam logic [3:0] OP_MUL  = 4'h9;
   localparam logic [3:0] OP_MULU = 4'hA;
   localparam logic [3:0] OP_DIV  = 4'hB;
   localparam logic [3:0] OP_DIVU = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op >= OP_MUL) && (op <= OP_DIVU);
   endfunction

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative unsigned multiply / restoring divide engine, one bit per step
// Purpose: operates on W-bit magnitudes; sign handling is done by the caller.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         capture ma/mb/is_div and clear the step counter
//   step         advance one iteration
//   is_div       1 = divide (ma / mb), 0 = multiply (ma * mb)
//   ma, mb       magnitude operands
//   last         counter has reached W-1 (current step is the final one)
//   hi, lo       multiply: {hi,lo} = product; divide: hi = remainder, lo = quotient
module seq_muldiv #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic         is_div,
   input  logic [W-1:0] ma,
   input  logic [W-1:0] mb,
   output logic         last,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);
   import alu_pkg::*;

   localparam int CW = $clog2(W + 1);

   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_hi;
   logic [W-1:0]  r_lo;
   logic [W-1:0]  r_opnd;
   logic          r_div;

   logic [W:0]    w_add;
   logic [W:0]    w_trial;
   logic [W:0]    w_diff;
   logic          w_ge;

   // Multiply: r_lo holds the remaining multiplier bits (LSB first), r_hi the
   // running upper partial product. Divide: {r_hi, r_lo} shifts the dividend
   // left into the remainder while quotient bits enter r_lo from the right.
   always_comb begin
      w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
      w_trial = {r_hi, r_lo[W-1]};
      w_ge    = (w_trial >= {1'b0, r_opnd});
      w_diff  = w_trial - {1'b0, r_opnd};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_opnd <= '0;
         r_div  <= 1'b0;
      end else if (load) begin
         r_cnt  <= '0;
         r_hi   <= '0;
         r_lo   <= is_div ? ma : mb;
         r_opnd <= is_div ? mb : ma;
         r_div  <= is_div;
      end else if (step) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_div) begin
            r_hi <= w_ge ? w_diff[W-1:0] : w_trial[W-1:0];
            r_lo <= {r_lo[W-2:0], w_ge};
         end else begin
            {r_hi, r_lo} <= {w_add, r_lo[W-1:1]};
         end
      end
   end

   assign last = (r_cnt == CW'(W - 1));
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: rtl/seq_alu_core.sv
// rtl/seq_alu_core.sv - multi-cycle ALU core with start/done handshake and status flags
// Purpose: single-cycle ALU ops plus iterative signed/unsigned multiply and divide.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   a, b, ctrl     operands and opcode, captured when start is accepted in IDLE
//   start          request (ignored while busy or while done is high)
//   busy           operation in flight
//   done           one-cycle pulse; result/flags valid from this cycle on
//   result         2*W-bit result, held until the next accepted start
//   zero, neg, ovf, cout, dz, illegal   status flags, updated together with done
module seq_alu_core #(
   parameter int W  = 6,
   parameter int SW = $clog2(W + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [3:0]     ctrl,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result,
   output logic           zero,
   output logic           neg,
   output logic           ovf,
   output logic           cout,
   output logic           dz,
   output logic           illegal
);
   import alu_pkg::*;

   state_t         r_state;
   state_t         w_next;
   logic [3:0]     r_op;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic           r_done;
   logic [2*W-1:0] r_result;
   logic           r_zero, r_neg, r_ovf, r_cout, r_dz, r_illegal;

   logic           w_accept;
   logic           w_signed_ld;
   logic [W-1:0]   w_ma, w_mb, w_hi, w_lo;
   logic           w_last;

   logic [W:0]     w_sum;
   logic [W-1:0]   w_alu;
   logic [SW-1:0]  w_amt;
   logic           w_big;
   logic [2*W-1:0] w_prod;
   logic [2*W-1:0] w_res;
   logic [W-1:0]   w_quot, w_rem;
   logic           w_ovf, w_cout, w_dz, w_ill;

   // The engine always works on magnitudes; signed ops strip the sign here
   // and restore it in the DONE-state result logic.
   assign w_signed_ld = (ctrl == OP_MUL) || (ctrl == OP_DIV);
   assign w_ma = (w_signed_ld && a[W-1]) ? -a : a;
   assign w_mb = (w_signed_ld && b[W-1]) ? -b : b;

   // Loaded on every accept: a MUL with b == 0 skips ITER and the freshly
   // loaded engine already reads back a zero product.
   seq_muldiv #(.W(W)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .load   (w_accept),
      .step   (r_state == ST_ITER),
      .is_div ((ctrl == OP_DIV) || (ctrl == OP_DIVU)),
      .ma     (w_ma),
      .mb     (w_mb),
      .last   (w_last),
      .hi     (w_hi),
      .lo     (w_lo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !r_done) begin
               w_accept = 1'b1;
               w_next   = (is_muldiv(ctrl) && (b != '0)) ? ST_ITER : ST_DONE;
            end
         end
         ST_ITER: if (w_last) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Result and flags, meaningful only while r_state == ST_DONE.
   always_comb begin
      w_sum  = '0;
      w_alu  = '0;
      w_ovf  = 1'b0;
      w_cout = 1'b0;
      w_dz   = 1'b0;
      w_ill  = 1'b0;
      w_res  = '0;
      w_amt  = r_b[SW-1:0];
      w_big  = (w_amt >= SW'(W));
      w_prod = {w_hi, w_lo};
      w_quot = w_lo;
      w_rem  = w_hi;
      case (r_op)
         OP_ADD: begin
            w_sum  = {1'b0, r_a} + {1'b0, r_b};
            w_alu  = w_sum[W-1:0];
            w_cout = w_sum[W];
            w_ovf  = (r_a[W-1] == r_b[W-1]) && (w_alu[W-1] != r_a[W-1]);
         end
         OP_SUB: begin
            w_sum  = {1'b0, r_a} + {1'b0, ~r_b} + {{W{1'b0}}, 1'b1};
            w_alu  = w_sum[W-1:0];
            w_cout = w_sum[W];
            w_ovf  = (r_a[W-1] != r_b[W-1]) && (w_alu[W-1] != r_a[W-1]);
         end
         OP_AND:  w_alu = r_a & r_b;
         OP_OR:   w_alu = r_a | r_b;
         OP_XOR:  w_alu = r_a ^ r_b;
         OP_SLL:  w_alu = w_big ? '0 : (r_a << w_amt);
         OP_SRL:  w_alu = w_big ? '0 : (r_a >> w_amt);
         OP_SRA:  w_alu = w_big ? {W{r_a[W-1]}} : W'($signed(r_a) >>> w_amt);
         OP_SLT:  w_alu = {{(W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
         OP_MUL:  w_res = (r_a[W-1] ^ r_b[W-1]) ? -w_prod : w_prod;
         OP_MULU: w_res = w_prod;
         OP_DIV, OP_DIVU: begin
            if (r_b == '0) begin
               w_dz  = 1'b1;
               w_res = {r_a, {W{1'b1}}};
            end else begin
               // Truncating division: quotient sign from the sign mismatch,
               // remainder sign from the dividend.
               if (r_op == OP_DIV) begin
                  if (r_a[W-1] ^ r_b[W-1]) w_quot = -w_lo;
                  if (r_a[W-1])            w_rem  = -w_hi;
               end
               w_res = {w_rem, w_quot};
            end
         end
         default: w_ill = 1'b1;
      endcase
      if (!is_muldiv(r_op)) begin
         w_res = {{W{w_alu[W-1]}}, w_alu};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_neg     <= 1'b0;
         r_ovf     <= 1'b0;
         r_cout    <= 1'b0;
         r_dz      <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_done <= (r_state == ST_DONE);
         if (w_accept) begin
            r_op <= ctrl;
            r_a  <= a;
            r_b  <= b;
         end
         if (r_state == ST_DONE) begin
            r_result  <= w_res;
            r_zero    <= (w_res == '0);
            r_neg     <= w_res[2*W-1];
            r_ovf     <= w_ovf;
            r_cout    <= w_cout;
            r_dz      <= w_dz;
            r_illegal <= w_ill;
         end
      end
   end

   assign busy    = (r_state != ST_IDLE);
   assign done    = r_done;
   assign result  = r_result;
   assign zero    = r_zero;
   assign neg     = r_neg;
   assign ovf     = r_ovf;
   assign cout    = r_cout;
   assign dz      = r_dz;
   assign illegal = r_illegal;

endmodule

// File: tb/tb_seq_alu_core.sv
// tb/tb_seq_alu_core.sv - self-checking bench for seq_alu_core (W=6)
module tb_seq_alu_core;
   import alu_pkg::*;

   localparam int W = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [3:0]    ctrl = '0;
   logic          busy, done, zero, neg, ovf, cout, dz, illegal;
   logic [2*W-1:0] result;

   seq_alu_core #(.W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .ctrl    (ctrl),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .zero    (zero),
      .neg     (neg),
      .ovf     (ovf),
      .cout    (cout),
      .dz      (dz),
      .illegal (illegal)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic        rst_seen = 1'b1;
   int          start_cyc = 0;
   int          exp_done_cyc = -1;
   logic [17:0] exp_out = '0;
   logic [17:0] hold = '0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endfunction

   // Reference model from arithmetic definitions: {result[11:0], zero, neg, ovf, cout, dz, illegal}.
   function automatic logic [17:0] model(input logic [3:0] op, input logic [5:0] x, input logic [5:0] y);
      int sx, sy, ux, uy, amt, t, q, rm;
      logic [31:0] v, vq, vr;
      logic [11:0] r;
      logic o, c, d, il;
      sx = $signed(x); sy = $signed(y); ux = int'(x); uy = int'(y); amt = int'(y[2:0]);
      o = 0; c = 0; d = 0; il = 0; t = 0; q = 0; rm = 0;
      case (op)
         OP_ADD:  begin t = ux + uy; c = (t > 63); o = (sx + sy > 31) || (sx + sy < -32); end
         OP_SUB:  begin t = ux - uy; c = (ux >= uy); o = (sx - sy > 31) || (sx - sy < -32); end
         OP_AND:  t = ux & uy;
         OP_OR:   t = ux | uy;
         OP_XOR:  t = ux ^ uy;
         OP_SLL:  t = (amt >= 6) ? 0 : (ux << amt);
         OP_SRL:  t = (amt >= 6) ? 0 : (ux >> amt);
         OP_SRA:  t = (amt >= 6) ? ((sx < 0) ? -1 : 0) : (sx >>> amt);
         OP_SLT:  t = (sx < sy) ? 1 : 0;
         OP_MUL:  t = sx * sy;
         OP_MULU: t = ux * uy;
         OP_DIV:  if (uy != 0) begin
                     if (sx == -32 && sy == -1) begin q = -32; rm = 0; end
                     else begin q = sx / sy; rm = sx % sy; end
                  end
         OP_DIVU: if (uy != 0) begin q = ux / uy; rm = ux % uy; end
         default: il = 1;
      endcase
      v = t; vq = q; vr = rm;
      if (op <= OP_SLT)                         r = {{6{v[5]}}, v[5:0]};
      else if (op == OP_MUL || op == OP_MULU)   r = v[11:0];
      else if (op == OP_DIV || op == OP_DIVU) begin
         if (uy == 0) begin r = {x, 6'h3F}; d = 1; end
         else r = {vr[5:0], vq[5:0]};
      end else r = 12'h000;
      return {r, (r == 12'h000), r[11], o, c, d, il};
   endfunction

   // Every cycle: reset state, done timing, busy, and held result/flags.
   always @(negedge clk) begin
      int  got;
      logic exp_busy;
      if (rst_seen) begin
         hold = '0;
         exp_done_cyc = -1;
         chk("reset_state", {result, zero, neg, ovf, cout, dz, illegal, busy, done}, 32'h0);
      end else begin
         exp_busy = (exp_done_cyc >= 0) && (cyc >= start_cyc) && (cyc < exp_done_cyc);
         if (done || (exp_done_cyc >= 0 && cyc >= exp_done_cyc)) begin
            got = done ? cyc : -2;
            chk("done_cycle", got, exp_done_cyc);
            if (done) hold = exp_out;
            exp_done_cyc = -1;
         end
         chk("busy", busy, exp_busy);
         chk("outputs", {result, zero, neg, ovf, cout, dz, illegal}, hold);
      end
   end

   // mode 0: plain; 1: re-pulse start two cycles into the op; 2: start while done is high
   task automatic run_op(input logic [3:0] op, input logic [5:0] x, input logic [5:0] y, input int mode);
      int s, k, lat;
      lat = ((op >= OP_MUL) && (op <= OP_DIVU) && (y != 0)) ? W + 1 : 1;
      @(negedge clk);
      ctrl = op; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      s = cyc;
      exp_out = model(op, x, y);
      start_cyc = s;
      exp_done_cyc = s + lat;
      @(negedge clk);
      start = 1'b0; a = ~x; b = ~y; ctrl = OP_ADD;
      k = 0;
      while (!done && k < 30) begin
         start = (mode == 1) && (cyc == s + 2);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      if (!done) chk("done_timeout", done, 1'b1);
      if (mode == 2) begin
         start = 1'b1; ctrl = OP_ADD; a = 6'd1; b = 6'd2;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      logic [17:0] m;
      int s;

      m = model(OP_MUL, 6'd9, 6'h3D);  chk("model_mul", m[17:6], 12'hFE5);
      m = model(OP_DIVU, 6'd9, 6'd2);  chk("model_divu", m[17:6], 12'h044);
      m = model(OP_SRA, 6'h20, 6'd7);  chk("model_sra", m[17:6], 12'hFFF);
      m = model(OP_DIV, 6'd7, 6'd0);   chk("model_dz", {m[17:6], m[1]}, {12'h1FF, 1'b1});

      repeat (3) @(negedge clk);
      rst = 1'b0;

      run_op(OP_MUL, 6'd9, 6'h3D, 0);   chk("mul_result", {result, neg, zero}, {12'hFE5, 2'b10});
      run_op(OP_DIV, 6'd9, 6'h3D, 0);   chk("div_result", result, 12'h03D);
      run_op(OP_DIVU, 6'd9, 6'd2, 0);   chk("divu_result", result, 12'h044);
      run_op(OP_ADD, 6'd31, 6'd1, 0);   chk("add_result", {result, ovf, cout}, {12'hFE0, 2'b10});
      run_op(OP_SUB, 6'd5, 6'd5, 0);    chk("sub_result", {result, zero, cout}, {12'h000, 2'b11});
      run_op(OP_DIV, 6'd7, 6'd0, 0);    chk("dz_result", {result, dz}, {12'h1FF, 1'b1});
      run_op(4'hE, 6'd3, 6'd4, 0);      chk("illegal_result", {result, illegal, zero}, {12'h000, 2'b11});
      run_op(OP_SRA, 6'h20, 6'd7, 0);   chk("sra_result", result, 12'hFFF);
      run_op(OP_SLL, 6'd1, 6'd6, 2);    chk("sll_result", result, 12'h000);
      run_op(OP_MUL, 6'h20, 6'h20, 1);  chk("mul_minmin", result, 12'h400);
      run_op(OP_MULU, 6'h3F, 6'h3F, 0); chk("mulu_max", result, 12'hF81);
      run_op(OP_DIV, 6'h20, 6'h3F, 0);  chk("div_minneg1", {result, dz}, {12'h020, 1'b0});
      run_op(OP_DIV, 6'h39, 6'd2, 0);   chk("div_negdividend", result, 12'hFFD);
      run_op(OP_MUL, 6'd5, 6'd0, 0);
      run_op(OP_SUB, 6'h20, 6'd1, 0);
      run_op(OP_AND, 6'h2A, 6'h0F, 0);
      run_op(OP_OR,  6'h2A, 6'h05, 0);
      run_op(OP_XOR, 6'h3F, 6'h15, 0);
      run_op(OP_SRL, 6'h30, 6'd2, 0);
      run_op(OP_SLT, 6'h3F, 6'd1, 0);
      run_op(OP_SLT, 6'd1, 6'h3F, 0);
      run_op(OP_DIVU, 6'd3, 6'd0, 0);

      // Abort an in-flight MUL with reset; the mid-op start must be ignored.
      @(negedge clk);
      ctrl = OP_MUL; a = 6'd9; b = 6'h3D; start = 1'b1;
      @(posedge clk); #1;
      s = cyc;
      exp_out = model(OP_MUL, 6'd9, 6'h3D);
      start_cyc = s;
      exp_done_cyc = s + W + 1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; ctrl = OP_ADD;
      @(negedge clk); start = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("abort_outputs", {result, done, busy}, 14'h0);
      repeat (10) @(negedge clk);
      run_op(OP_ADD, 6'd2, 6'd3, 0);    chk("after_abort_add", result, 12'h005);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
